// File: rtl/mem_range_sum_if.sv
// rtl/mem_range_sum_if.sv - request/ready handshake between the range sequencer and the 16 x 32-bit row memory
interface mem_range_sum_if;
  logic [3:0]  mem_row;
  logic        mem_valid;
  logic [31:0] mem_out;
  logic        mem_ready;

  modport master (output mem_row, output mem_valid, input mem_out, input mem_ready);
  modport slave  (input mem_row, input mem_valid, output mem_out, output mem_ready);
endinterface

// File: rtl/mem_range_sum.sv
// rtl/mem_range_sum.sv - wrapping row-range read sequencer and wide accumulator
// Optional macro MAX_TRACK_EN adds a running unsigned maximum of the words read.
module mem_range_sum #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int SUM_W          = 36
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       start_row,
  input  logic [3:0]       end_row,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [SUM_W-1:0] sum,
  output logic [31:0]      max_val,
  mem_range_sum_if.master  mem
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [SUM_W-1:0] r_sum;
  logic [3:0]       r_row;
  logic             r_valid;
  logic [3:0]       r_rows_m1;
  logic [4:0]       r_cnt;
  logic [7:0]       r_tcnt;
  logic             r_ready_q;

  // Only a rising edge of ready counts, so a held level never completes a second row.
  logic             w_accept;
  logic             w_last;
  logic             w_expired;
  logic [SUM_W-1:0] w_word;

  assign w_accept  = mem.mem_ready & ~r_ready_q;
  assign w_last    = (r_cnt == {1'b0, r_rows_m1});
  assign w_expired = (r_tcnt == 8'(TIMEOUT_CYCLES - 1));
  assign w_word    = {{(SUM_W-32){1'b0}}, mem.mem_out};

`ifdef MAX_TRACK_EN
  logic [31:0] r_max;
  assign max_val = r_max;
`else
  assign max_val = '0;
`endif

  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign sum           = r_sum;
  assign mem.mem_row   = r_row;
  assign mem.mem_valid = r_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_sum     <= '0;
      r_row     <= '0;
      r_valid   <= 1'b0;
      r_rows_m1 <= '0;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_ready_q <= 1'b0;
`ifdef MAX_TRACK_EN
      r_max     <= '0;
`endif
    end else begin
      r_ready_q <= mem.mem_ready;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // 4-bit subtraction wraps, giving (end - start) mod 16 directly.
            r_rows_m1 <= end_row - start_row;
            r_row     <= start_row;
            r_sum     <= '0;
            r_error   <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_valid   <= 1'b1;
            r_state   <= S_ISSUE;
`ifdef MAX_TRACK_EN
            r_max     <= '0;
`endif
          end
        end
        S_ISSUE: begin
          r_tcnt  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_accept) begin
            r_sum <= r_sum + w_word;
            r_cnt <= r_cnt + 5'd1;
`ifdef MAX_TRACK_EN
            if (mem.mem_out > r_max) r_max <= mem.mem_out;
`endif
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_row   <= r_row + 4'd1;
              r_valid <= 1'b1;
              r_state <= S_ISSUE;
            end
          end else if (w_expired) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
